telemetry_framer: RTL and testbench

TELEMETRY_FRAMER -- requirements
Module: telemetry_framer

---
 rtl/telemetry_pkg.sv | 25 ++
 rtl/telemetry_pkt_fifo.sv | 57 +++++
 rtl/telemetry_framer.sv | 173 +++++++++++++++++
 tb/tb_telemetry_framer.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/telemetry_pkg.sv
// Shared definitions for the telemetry framer: line symbols, CRC-8 helper and
// symbol FSM state encoding.
package telemetry_pkg;

  localparam logic [7:0] K28_5     = 8'hBC;
  localparam logic [7:0] K28_1     = 8'h3C;
  localparam logic [7:0] CRC8_POLY = 8'h07;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_SOP     = 3'd1;
  localparam logic [2:0] ST_PAYLOAD = 3'd2;
  localparam logic [2:0] ST_CRC     = 3'd3;
  localparam logic [2:0] ST_GAP     = 3'd4;

  // One byte of MSB-first CRC-8 (init and reflection handled by the caller).
  function automatic logic [7:0] crc8_update(input logic [7:0] crc, input logic [7:0] data);
    logic [7:0] c;
    c = crc ^ data;
    for (int i = 0; i < 8; i++) begin
      c = c[7] ? ((c << 1) ^ CRC8_POLY) : (c << 1);
    end
    return c;
  endfunction

endpackage

// File: rtl/telemetry_pkt_fifo.sv
// Packet-wide FIFO: one slot holds a whole payload word; head is visible
// combinationally on rd_data.
module telemetry_pkt_fifo #(
  parameter int WIDTH = 88,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [LW-1:0]    level_q;
  logic             full;
  logic             do_wr;
  logic             do_rd;

  assign empty   = (level_q == '0);
  assign full    = (level_q == LW'(DEPTH));
  assign level   = level_q;
  assign rd_data = mem_q[rd_ptr_q];

  // A write into a full FIFO is legal when the head leaves in the same cycle.
  assign do_rd = rd_en & ~empty;
  assign do_wr = wr_en & (~full | do_rd);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (do_wr) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_rd) rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({do_wr, do_rd})
        2'b10:   level_q <= level_q + LW'(1);
        2'b01:   level_q <= level_q - LW'(1);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem_q[wr_ptr_q] <= wr_data;
  end

endmodule

// File: rtl/telemetry_framer.sv
// Telemetry framer: queues whole packets and serialises them as
// SOP / payload / CRC / idle-gap symbols for a downstream 8b10b encoder.
module telemetry_framer
  import telemetry_pkg::*;
#(
  parameter int         G_PACKET_BYTES = 11,
  parameter int         G_FIFO_DEPTH   = 4,
  parameter int         G_MIN_GAP      = 1,
  parameter logic       G_CRC_EN       = 1'b1,
  parameter logic [7:0] G_K_SOP        = K28_5,
  parameter logic [7:0] G_K_IDLE       = K28_1
) (
  input  logic                          clk,
  input  logic                          reset_clk_n,
  input  logic [8*G_PACKET_BYTES-1:0]   packet,
  input  logic                          packet_valid,
  output logic                          packet_ready,
  input  logic                          sym_en,
  output logic [7:0]                    data_out,
  output logic                          k_out,
  output logic                          valid_out,
  output logic [$clog2(G_FIFO_DEPTH):0] fifo_level,
  output logic                          overflow,
  output logic [15:0]                   pkt_count,
  output logic [2:0]                    dbg_state
);

  localparam int         PW       = 8 * G_PACKET_BYTES;
  localparam int         LW       = $clog2(G_FIFO_DEPTH) + 1;
  localparam logic [4:0] LAST_IDX = 5'(G_PACKET_BYTES - 1);
  localparam logic [3:0] LAST_GAP = 4'(G_MIN_GAP - 1);

  logic [2:0]    state_q, state_d;
  logic [4:0]    idx_q, idx_d;
  logic [3:0]    gap_q, gap_d;
  logic [PW-1:0] shreg_q, shreg_d;
  logic [7:0]    crc_q, crc_d;
  logic [7:0]    data_q;
  logic          k_q;
  logic          valid_q;
  logic          overflow_q;
  logic [15:0]   pkt_cnt_q;

  logic [PW-1:0] fifo_head;
  logic          fifo_empty;
  logic          pop;
  logic          wr_ok;
  logic          pkt_done;
  logic          launch;
  logic [7:0]    sym;
  logic          sym_k;

  // Handshake: a packet is taken on any edge where packet_valid is high and
  // either a slot is free (packet_ready) or the head is popped that same edge;
  // otherwise it is dropped and overflow pulses for one cycle.
  assign packet_ready = (fifo_level < LW'(G_FIFO_DEPTH));
  assign wr_ok        = packet_valid & (packet_ready | pop);

  telemetry_pkt_fifo #(
    .WIDTH (PW),
    .DEPTH (G_FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (reset_clk_n),
    .wr_en   (wr_ok),
    .wr_data (packet),
    .rd_en   (pop),
    .rd_data (fifo_head),
    .level   (fifo_level),
    .empty   (fifo_empty)
  );

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    gap_d    = gap_q;
    shreg_d  = shreg_q;
    crc_d    = crc_q;
    sym      = G_K_IDLE;
    sym_k    = 1'b1;
    pop      = 1'b0;
    pkt_done = 1'b0;
    launch   = 1'b0;

    case (state_q)
      ST_SOP:     sym = G_K_SOP;
      ST_PAYLOAD: begin sym = shreg_q[PW-1 -: 8]; sym_k = 1'b0; end
      ST_CRC:     begin sym = crc_q;              sym_k = 1'b0; end
      default:    ;
    endcase

    if (sym_en) begin
      case (state_q)
        ST_IDLE: launch = 1'b1;
        ST_SOP: begin
          state_d = ST_PAYLOAD;
          idx_d   = '0;
        end
        ST_PAYLOAD: begin
          crc_d   = crc8_update(crc_q, sym);
          shreg_d = shreg_q << 8;
          idx_d   = idx_q + 5'd1;
          if (idx_q == LAST_IDX) begin
            if (G_CRC_EN) state_d  = ST_CRC;
            else          pkt_done = 1'b1;
          end
        end
        ST_CRC: pkt_done = 1'b1;
        ST_GAP: begin
          gap_d = gap_q + 4'd1;
          if (gap_q == LAST_GAP) launch = 1'b1;
        end
        default: state_d = ST_IDLE;
      endcase

      // With no gap configured, the symbol after the last byte can be SOP.
      if (pkt_done) begin
        if (G_MIN_GAP == 0) launch = 1'b1;
        else begin
          state_d = ST_GAP;
          gap_d   = '0;
        end
      end

      if (launch) begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          shreg_d = fifo_head;
          crc_d   = '0;
          state_d = ST_SOP;
        end else begin
          state_d = ST_IDLE;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_clk_n) begin
      state_q    <= ST_IDLE;
      idx_q      <= '0;
      gap_q      <= '0;
      shreg_q    <= '0;
      crc_q      <= '0;
      data_q     <= G_K_IDLE;
      k_q        <= 1'b1;
      valid_q    <= 1'b0;
      overflow_q <= 1'b0;
      pkt_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      gap_q      <= gap_d;
      shreg_q    <= shreg_d;
      crc_q      <= crc_d;
      valid_q    <= sym_en;
      overflow_q <= packet_valid & ~wr_ok;
      if (sym_en) begin
        data_q <= sym;
        k_q    <= sym_k;
      end
      if (pkt_done) pkt_cnt_q <= pkt_cnt_q + 16'd1;
    end
  end

  assign data_out  = data_q;
  assign k_out     = k_q;
  assign valid_out = valid_q;
  assign overflow  = overflow_q;
  assign pkt_count = pkt_cnt_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_telemetry_framer.sv
// Bench for telemetry_framer: default instance plus a no-gap, no-CRC instance,
// each with an expected-symbol queue drained by its own monitor.
module tb_telemetry_framer;
  import telemetry_pkg::*;

  localparam int NB = 11;
  localparam int PW = 8 * NB;

  localparam logic [PW-1:0] P0 = 88'h00112233445566778899AA;
  localparam logic [PW-1:0] PA = 88'h01;
  localparam logic [PW-1:0] PB = 88'h02;
  localparam logic [PW-1:0] PC = 88'h11;
  localparam logic [PW-1:0] PD = 88'h00;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset_clk_n;
  logic          sym_en;
  logic          valid_a, valid_b;
  logic [PW-1:0] packet;

  logic       ready_a, k_a, vout_a, ovf_a;
  logic [7:0] data_a;
  logic [2:0] level_a, state_a;
  logic [15:0] cnt_a;
  logic       ready_b, k_b, vout_b, ovf_b;
  logic [7:0] data_b;
  logic [2:0] level_b, state_b;
  logic [15:0] cnt_b;

  telemetry_framer dut_a (
    .clk(clk), .reset_clk_n(reset_clk_n), .packet(packet), .packet_valid(valid_a),
    .packet_ready(ready_a), .sym_en(sym_en), .data_out(data_a), .k_out(k_a),
    .valid_out(vout_a), .fifo_level(level_a), .overflow(ovf_a), .pkt_count(cnt_a),
    .dbg_state(state_a)
  );

  telemetry_framer #(.G_MIN_GAP(0), .G_CRC_EN(1'b0)) dut_b (
    .clk(clk), .reset_clk_n(reset_clk_n), .packet(packet), .packet_valid(valid_b),
    .packet_ready(ready_b), .sym_en(sym_en), .data_out(data_b), .k_out(k_b),
    .valid_out(vout_b), .fifo_level(level_b), .overflow(ovf_b), .pkt_count(cnt_b),
    .dbg_state(state_b)
  );

  int checks = 0;
  int errors = 0;

  // entry = {leading idles may precede, k, data}
  logic [9:0] exp_q[$];
  logic [9:0] exp_b_q[$];
  logic [9:0] e_a, e_b;

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic push_a(input logic [PW-1:0] p, input logic lead, input logic [7:0] crc);
    exp_q.push_back({lead, 1'b1, K28_5});
    for (int i = 0; i < NB; i++) exp_q.push_back({2'b00, p[PW-1-8*i -: 8]});
    exp_q.push_back({2'b00, crc});
    exp_q.push_back({2'b01, K28_1});
  endtask

  task automatic push_b(input logic [PW-1:0] p, input logic lead);
    exp_b_q.push_back({lead, 1'b1, K28_5});
    for (int i = 0; i < NB; i++) exp_b_q.push_back({2'b00, p[PW-1-8*i -: 8]});
  endtask

  task automatic send_a(input logic [PW-1:0] p);
    packet  = p;
    valid_a = 1'b1;
    tick();
    valid_a = 1'b0;
  endtask

  task automatic send_b(input logic [PW-1:0] p);
    packet  = p;
    valid_b = 1'b1;
    tick();
    valid_b = 1'b0;
  endtask

  task automatic wait_drain(input bit use_b, input int bound, input string name);
    int n;
    n = 0;
    while ((use_b ? exp_b_q.size() : exp_q.size()) != 0 && n < bound) begin
      tick();
      n++;
    end
    checks++;
    if ((use_b ? exp_b_q.size() : exp_q.size()) != 0) begin
      errors++;
      $display("FAIL %s drain: %0d symbols still expected after %0d cycles", name,
               use_b ? exp_b_q.size() : exp_q.size(), bound);
    end
  endtask

  // scoreboard monitors
  always @(negedge clk) begin
    if (reset_clk_n && vout_a) begin
      if (!(k_a && data_a == K28_1 && (exp_q.size() == 0 || exp_q[0][9]))) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL sym_a unexpected: got k=%0b data=%02h, expected line idle", k_a, data_a);
        end else begin
          e_a = exp_q.pop_front();
          if ({k_a, data_a} !== e_a[8:0]) begin
            errors++;
            $display("FAIL sym_a: got k=%0b data=%02h, expected k=%0b data=%02h",
                     k_a, data_a, e_a[8], e_a[7:0]);
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    if (reset_clk_n && vout_b) begin
      if (!(k_b && data_b == K28_1 && (exp_b_q.size() == 0 || exp_b_q[0][9]))) begin
        checks++;
        if (exp_b_q.size() == 0) begin
          errors++;
          $display("FAIL sym_b unexpected: got k=%0b data=%02h, expected line idle", k_b, data_b);
        end else begin
          e_b = exp_b_q.pop_front();
          if ({k_b, data_b} !== e_b[8:0]) begin
            errors++;
            $display("FAIL sym_b: got k=%0b data=%02h, expected k=%0b data=%02h",
                     k_b, data_b, e_b[8], e_b[7:0]);
          end
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached, errors=%0d", errors);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int se, vo, n;
    logic [8:0] prev;

    reset_clk_n = 1'b0;
    sym_en      = 1'b0;
    valid_a     = 1'b0;
    valid_b     = 1'b0;
    packet      = '0;
    tick();
    tick();
    check("rst data_out", data_a, 8'h3C);
    check("rst k_out", k_a, 1'b1);
    check("rst valid_out", vout_a, 1'b0);
    check("rst fifo_level", level_a, 3'd0);
    check("rst pkt_count", cnt_a, 16'd0);
    check("rst overflow", ovf_a, 1'b0);
    reset_clk_n = 1'b1;
    tick();
    check("ready after release", ready_a, 1'b1);

    // single packet, latency and CRC
    sym_en = 1'b1;
    tick();
    push_a(P0, 1'b1, 8'hD2);
    send_a(P0);
    tick();
    check("lat t+1 idle", {k_a, data_a}, {1'b1, 8'h3C});
    tick();
    check("lat t+2 sop", {k_a, data_a}, {1'b1, 8'hBC});
    check("lat valid_out", vout_a, 1'b1);
    wait_drain(1'b0, 60, "basic");
    tick();
    check("basic pkt_count", cnt_a, 16'd1);
    check("basic state", state_a, ST_IDLE);

    // 8-of-10 symbol enable
    push_a(P0, 1'b1, 8'hD2);
    send_a(P0);
    se = 0;
    vo = 0;
    for (int i = 0; i < 60; i++) begin
      sym_en = (i % 10 < 8);
      prev   = {k_a, data_a};
      tick();
      se += int'(sym_en);
      vo += int'(vout_a);
      if (!sym_en) check("hold on sym_en=0", {k_a, data_a}, prev);
    end
    sym_en = 1'b1;
    wait_drain(1'b0, 60, "sym_en pattern");
    check("valid_out count", vo, se);
    check("pattern pkt_count", cnt_a, 16'd2);

    // fill, overflow, then back-to-back drain
    sym_en = 1'b0;
    tick();
    push_a(PA, 1'b1, 8'h07); send_a(PA);
    push_a(PB, 1'b0, 8'h0E); send_a(PB);
    push_a(PC, 1'b0, 8'h77); send_a(PC);
    push_a(PD, 1'b0, 8'h00); send_a(PD);
    check("full level", level_a, 3'd4);
    check("full ready", ready_a, 1'b0);
    check("no overflow yet", ovf_a, 1'b0);
    send_a(P0);
    check("overflow pulse", ovf_a, 1'b1);
    check("level after drop", level_a, 3'd4);
    tick();
    check("overflow one cycle", ovf_a, 1'b0);
    sym_en = 1'b1;
    wait_drain(1'b0, 200, "burst");
    repeat (20) tick();
    check("burst pkt_count", cnt_a, 16'd6);
    check("burst level", level_a, 3'd0);

    // full FIFO with simultaneous write and pop
    sym_en = 1'b0;
    tick();
    push_a(PA, 1'b1, 8'h07); send_a(PA);
    push_a(PB, 1'b0, 8'h0E); send_a(PB);
    push_a(PC, 1'b0, 8'h77); send_a(PC);
    push_a(PD, 1'b0, 8'h00); send_a(PD);
    check("refill level", level_a, 3'd4);
    push_a(P0, 1'b0, 8'hD2);
    packet  = P0;
    valid_a = 1'b1;
    sym_en  = 1'b1;
    tick();
    valid_a = 1'b0;
    check("wr+pop overflow", ovf_a, 1'b0);
    check("wr+pop level", level_a, 3'd4);
    wait_drain(1'b0, 300, "wr+pop");
    repeat (5) tick();
    check("wr+pop pkt_count", cnt_a, 16'd11);

    // reset in the middle of a payload
    push_a(P0, 1'b1, 8'hD2); send_a(P0);
    push_a(PC, 1'b0, 8'h77); send_a(PC);
    n = 0;
    while (!(vout_a && !k_a && data_a == 8'h55) && n < 50) begin
      tick();
      n++;
    end
    check("reached payload byte 5", {k_a, data_a}, {1'b0, 8'h55});
    reset_clk_n = 1'b0;
    tick();
    exp_q.delete();
    check("mid rst valid_out", vout_a, 1'b0);
    check("mid rst symbol", {k_a, data_a}, {1'b1, 8'h3C});
    check("mid rst level", level_a, 3'd0);
    check("mid rst pkt_count", cnt_a, 16'd0);
    reset_clk_n = 1'b1;
    tick();
    check("post rst symbol", {k_a, data_a}, {1'b1, 8'h3C});
    check("post rst valid_out", vout_a, 1'b1);
    check("post rst level", level_a, 3'd0);
    check("post rst ready", ready_a, 1'b1);
    repeat (30) tick();
    check("post rst pkt_count", cnt_a, 16'd0);

    // zero gap, no CRC instance
    sym_en = 1'b0;
    tick();
    push_b(PA, 1'b1); send_b(PA);
    push_b(PB, 1'b0); send_b(PB);
    check("b level", level_b, 3'd2);
    sym_en = 1'b1;
    wait_drain(1'b1, 100, "no-gap");
    repeat (5) tick();
    check("b pkt_count", cnt_b, 16'd2);
    check("b state", state_b, ST_IDLE);
    check("b overflow", ovf_b, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
